// File: rtl/cam_frame_profiler_if.sv
// Camera strobe inputs and measurement results of cam_frame_profiler.
interface cam_frame_profiler_if #(
  parameter int unsigned BYTE_W = 20,
  parameter int unsigned LINE_W = 12
);
  logic              href;
  logic              vsync;
  logic              arm;
  logic [BYTE_W-1:0] frame_bytes;
  logic [BYTE_W-1:0] line_bytes;
  logic [LINE_W-1:0] line_count;
  logic              line_mismatch;
  logic              overflow;
  logic              result_valid;
  logic              done_pulse;
  logic              busy;

  modport master (
    output href, vsync, arm,
    input  frame_bytes, line_bytes, line_count, line_mismatch,
    input  overflow, result_valid, done_pulse, busy
  );

  modport slave (
    input  href, vsync, arm,
    output frame_bytes, line_bytes, line_count, line_mismatch,
    output overflow, result_valid, done_pulse, busy
  );
endinterface

// File: rtl/cam_frame_profiler.sv
// Measures camera frame geometry (bytes, first-line length, line count,
// line-length consistency) between consecutive vsync frame edges.
module cam_frame_profiler #(
  parameter int unsigned BYTE_W         = 20,
  parameter int unsigned LINE_W         = 12,
  parameter bit          VSYNC_ACT_HIGH = 1'b1,
  parameter bit          CONTINUOUS     = 1'b0
) (
  input  logic                pclk,
  input  logic                reset,
  cam_frame_profiler_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SYNC  = 2'd1;
  localparam logic [1:0] COUNT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state, state_nxt;
  logic              href_d, vs_act_d;
  logic              vs_act, frame_edge, line_end, byte_stb;

  logic [BYTE_W-1:0] cur_line, cur_frame, first_line;
  logic [LINE_W-1:0] cur_lines;
  logic              first_seen, mm, ovf;
  logic [BYTE_W-1:0] cur_line_nxt, cur_frame_nxt, first_line_nxt;
  logic [LINE_W-1:0] cur_lines_nxt;
  logic              first_seen_nxt, mm_nxt, ovf_nxt;
  logic              clear_work;

  logic [BYTE_W-1:0] frame_bytes, line_bytes;
  logic [LINE_W-1:0] line_count;
  logic              line_mismatch, overflow, result_valid, done_pulse, busy;

  assign bus.frame_bytes   = frame_bytes;
  assign bus.line_bytes    = line_bytes;
  assign bus.line_count    = line_count;
  assign bus.line_mismatch = line_mismatch;
  assign bus.overflow      = overflow;
  assign bus.result_valid  = result_valid;
  assign bus.done_pulse    = done_pulse;
  assign bus.busy          = busy;

  // Strobe decode: polarity-normalised vsync, frame edge, line end, byte strobe.
  always_comb begin
    vs_act     = VSYNC_ACT_HIGH ? bus.vsync : ~bus.vsync;
    frame_edge = vs_act & ~vs_act_d;
    line_end   = href_d & ~bus.href;
    byte_stb   = bus.href & ~vs_act;
  end

  // State register.
  always_ff @(posedge pclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; arm only matters in single-shot mode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (CONTINUOUS || bus.arm) state_nxt = SYNC;
      SYNC:    if (frame_edge) state_nxt = COUNT;
      COUNT:   if (frame_edge && !CONTINUOUS) state_nxt = DONE;
      DONE:    if (bus.arm && !CONTINUOUS) state_nxt = SYNC;
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating work counters; a line end in the edge cycle is folded in here.
  always_comb begin
    cur_line_nxt   = cur_line;
    cur_frame_nxt  = cur_frame;
    cur_lines_nxt  = cur_lines;
    first_line_nxt = first_line;
    first_seen_nxt = first_seen;
    mm_nxt         = mm;
    ovf_nxt        = ovf;
    if (byte_stb) begin
      if (&cur_line) ovf_nxt = 1'b1;
      else           cur_line_nxt = cur_line + BYTE_W'(1);
      if (&cur_frame) ovf_nxt = 1'b1;
      else            cur_frame_nxt = cur_frame + BYTE_W'(1);
    end
    if (line_end) begin
      if (&cur_lines) ovf_nxt = 1'b1;
      else            cur_lines_nxt = cur_lines + LINE_W'(1);
      if (!first_seen) begin
        first_line_nxt = cur_line;
        first_seen_nxt = 1'b1;
      end else if (cur_line != first_line) begin
        mm_nxt = 1'b1;
      end
      cur_line_nxt = '0;
    end
    clear_work = (state == SYNC) || ((state == COUNT) && frame_edge);
  end

  // Work counters, result registers and status flags.
  always_ff @(posedge pclk) begin
    if (reset) begin
      href_d        <= 1'b0;
      vs_act_d      <= 1'b1;
      cur_line      <= '0;
      cur_frame     <= '0;
      cur_lines     <= '0;
      first_line    <= '0;
      first_seen    <= 1'b0;
      mm            <= 1'b0;
      ovf           <= 1'b0;
      frame_bytes   <= '1;
      line_bytes    <= '1;
      line_count    <= '1;
      line_mismatch <= 1'b0;
      overflow      <= 1'b0;
      result_valid  <= 1'b0;
      done_pulse    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      href_d     <= bus.href;
      vs_act_d   <= vs_act;
      done_pulse <= 1'b0;
      busy       <= (state_nxt == SYNC) || (state_nxt == COUNT);
      if ((state == COUNT) && frame_edge) begin
        frame_bytes   <= cur_frame_nxt;
        line_bytes    <= first_line_nxt;
        line_count    <= cur_lines_nxt;
        line_mismatch <= mm_nxt;
        overflow      <= ovf_nxt;
        result_valid  <= 1'b1;
        done_pulse    <= 1'b1;
      end
      if ((state == DONE) && bus.arm && !CONTINUOUS) result_valid <= 1'b0;
      if (clear_work) begin
        cur_line   <= '0;
        cur_frame  <= '0;
        cur_lines  <= '0;
        first_line <= '0;
        first_seen <= 1'b0;
        mm         <= 1'b0;
        ovf        <= 1'b0;
      end else if (state == COUNT) begin
        cur_line   <= cur_line_nxt;
        cur_frame  <= cur_frame_nxt;
        cur_lines  <= cur_lines_nxt;
        first_line <= first_line_nxt;
        first_seen <= first_seen_nxt;
        mm         <= mm_nxt;
        ovf        <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cam_frame_profiler.sv
// Self-checking bench for cam_frame_profiler: three configurations
// (single-shot high vsync, continuous low vsync, narrow continuous).
`timescale 1ns/1ps
module tb_cam_frame_profiler;

  typedef struct packed {
    logic [31:0] fb;
    logic [31:0] lb;
    logic [31:0] lc;
    logic        mm;
    logic        ov;
    logic        rv;
  } res_t;

  logic pclk = 1'b0;
  logic reset = 1'b1;
  always #5 pclk = ~pclk;

  // Normalised stimulus: vs_s = 1 means blanking regardless of polarity.
  logic href_s[3];
  logic vs_s[3];
  logic arm_s[3];

  cam_frame_profiler_if #(.BYTE_W(20), .LINE_W(12)) if0 ();
  cam_frame_profiler_if #(.BYTE_W(20), .LINE_W(12)) if1 ();
  cam_frame_profiler_if #(.BYTE_W(4),  .LINE_W(12)) if2 ();

  cam_frame_profiler #(.BYTE_W(20), .LINE_W(12), .VSYNC_ACT_HIGH(1'b1), .CONTINUOUS(1'b0))
    u0 (.pclk(pclk), .reset(reset), .bus(if0));
  cam_frame_profiler #(.BYTE_W(20), .LINE_W(12), .VSYNC_ACT_HIGH(1'b0), .CONTINUOUS(1'b1))
    u1 (.pclk(pclk), .reset(reset), .bus(if1));
  cam_frame_profiler #(.BYTE_W(4), .LINE_W(12), .VSYNC_ACT_HIGH(1'b1), .CONTINUOUS(1'b1))
    u2 (.pclk(pclk), .reset(reset), .bus(if2));

  assign if0.href  = href_s[0];
  assign if0.vsync = vs_s[0];
  assign if0.arm   = arm_s[0];
  assign if1.href  = href_s[1];
  assign if1.vsync = ~vs_s[1];
  assign if1.arm   = arm_s[1];
  assign if2.href  = href_s[2];
  assign if2.vsync = vs_s[2];
  assign if2.arm   = arm_s[2];

  res_t live[3];
  logic dp_l[3];
  logic busy_l[3];
  assign live[0] = {32'(if0.frame_bytes), 32'(if0.line_bytes), 32'(if0.line_count),
                    if0.line_mismatch, if0.overflow, if0.result_valid};
  assign live[1] = {32'(if1.frame_bytes), 32'(if1.line_bytes), 32'(if1.line_count),
                    if1.line_mismatch, if1.overflow, if1.result_valid};
  assign live[2] = {32'(if2.frame_bytes), 32'(if2.line_bytes), 32'(if2.line_count),
                    if2.line_mismatch, if2.overflow, if2.result_valid};
  assign dp_l[0] = if0.done_pulse;
  assign dp_l[1] = if1.done_pulse;
  assign dp_l[2] = if2.done_pulse;
  assign busy_l[0] = if0.busy;
  assign busy_l[1] = if1.busy;
  assign busy_l[2] = if2.busy;

  int   n_pass = 0;
  int   n_tot  = 0;
  int   dp_cnt[3] = '{0, 0, 0};
  int   width_err = 0;
  logic dp_prev[3] = '{1'b0, 1'b0, 1'b0};
  res_t last[3];
  int   lens[$];

  // Capture results on each done pulse and flag pulses wider than one cycle.
  always @(negedge pclk) begin
    for (int i = 0; i < 3; i++) begin
      if (dp_l[i] === 1'b1) begin
        dp_cnt[i]++;
        last[i] = live[i];
        if (dp_prev[i] === 1'b1) width_err++;
      end
      dp_prev[i] = dp_l[i];
    end
  end

  function automatic string fmt(input res_t r);
    return $sformatf("fb=%0d lb=%0d lc=%0d mm=%0d ov=%0d rv=%0d",
                     r.fb, r.lb, r.lc, r.mm, r.ov, r.rv);
  endfunction

  function automatic res_t mk(input int fb, input int lb, input int lc,
                              input bit mm, input bit ov, input bit rv);
    res_t r;
    r = {32'(fb), 32'(lb), 32'(lc), mm, ov, rv};
    return r;
  endfunction

  function automatic res_t rst_val(input int i);
    int bmax;
    bmax = (i == 2) ? 15 : 32'h000F_FFFF;
    return mk(bmax, bmax, 4095, 1'b0, 1'b0, 1'b0);
  endfunction

  // Reference: frame statistics from the list of line lengths plus any
  // trailing partial line, with counters clamped at their maximum.
  function automatic res_t model(input int bw, input int partial);
    int bmax, total, l0, li;
    bit mm, ov;
    bmax  = (1 << bw) - 1;
    total = partial;
    mm    = 1'b0;
    ov    = (partial > bmax);
    l0    = 0;
    if (lens.size() > 0) l0 = (lens[0] > bmax) ? bmax : lens[0];
    foreach (lens[k]) begin
      total += lens[k];
      if (lens[k] > bmax) ov = 1'b1;
      li = (lens[k] > bmax) ? bmax : lens[k];
      if (k > 0 && li != l0) mm = 1'b1;
    end
    if (total > bmax) ov = 1'b1;
    if (lens.size() > 4095) ov = 1'b1;
    return mk((total > bmax) ? bmax : total, l0, lens.size(), mm, ov, 1'b1);
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic do_arm(input int i);
    arm_s[i] = 1'b1;
    tick();
    arm_s[i] = 1'b0;
  endtask

  task automatic vpulse(input int i);
    vs_s[i] = 1'b1;
    repeat (3) tick();
    vs_s[i] = 1'b0;
    repeat (3) tick();
  endtask

  // Drives the lines in 'lens', an optional partial line, then the closing vsync.
  task automatic send_frame(input int i, input bit same, input int partial);
    bit raised;
    raised = 1'b0;
    foreach (lens[k]) begin
      href_s[i] = 1'b1;
      repeat (lens[k]) tick();
      href_s[i] = 1'b0;
      if (same && partial == 0 && k == lens.size() - 1) begin
        vs_s[i] = 1'b1;
        raised = 1'b1;
        tick();
      end else begin
        repeat (3) tick();
      end
    end
    if (partial > 0) begin
      href_s[i] = 1'b1;
      repeat (partial) tick();
      vs_s[i] = 1'b1;
      raised = 1'b1;
      tick();
      href_s[i] = 1'b0;
    end
    if (!raised) begin
      vs_s[i] = 1'b1;
      tick();
    end
    repeat (3) tick();
    vs_s[i] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      n_tot++;
      if (live[i] !== rst_val(i))
        $display("FAIL reset_outputs[%0d]: got %s want %s", i, fmt(live[i]), fmt(rst_val(i)));
      else n_pass++;
      n_tot++;
      if ({busy_l[i], dp_l[i]} !== 2'b00)
        $display("FAIL reset_busy_dp[%0d]: got busy=%b dp=%b want 0 0", i, busy_l[i], dp_l[i]);
      else n_pass++;
    end
  endtask

  task automatic test_single_shot();
    int base;
    res_t e;
    e = mk(24, 8, 3, 1'b0, 1'b0, 1'b1);
    do_arm(0);
    n_tot++;
    if (busy_l[0] !== 1'b1) $display("FAIL arm_busy: got %b want 1", busy_l[0]);
    else n_pass++;
    base = dp_cnt[0];
    vpulse(0);
    lens = '{8, 8, 8};
    send_frame(0, 1'b0, 0);
    n_tot++;
    if (dp_cnt[0] - base !== 1) $display("FAIL ss_done_count: got %0d want 1", dp_cnt[0] - base);
    else n_pass++;
    n_tot++;
    if (live[0] !== e) $display("FAIL ss_3x8: got %s want %s", fmt(live[0]), fmt(e));
    else n_pass++;
    lens = '{4, 4};
    vpulse(0);
    send_frame(0, 1'b0, 0);
    n_tot++;
    if (live[0] !== e || dp_cnt[0] - base !== 1)
      $display("FAIL ss_hold: got %s pulses=%0d want %s pulses=1", fmt(live[0]), dp_cnt[0] - base, fmt(e));
    else n_pass++;
    n_tot++;
    if (busy_l[0] !== 1'b0) $display("FAIL ss_done_busy: got %b want 0", busy_l[0]);
    else n_pass++;
  endtask

  task automatic test_mismatch();
    res_t e;
    e = mk(23, 8, 3, 1'b1, 1'b0, 1'b1);
    do_arm(0);
    n_tot++;
    if (live[0].rv !== 1'b0) $display("FAIL rearm_valid: got %b want 0", live[0].rv);
    else n_pass++;
    vpulse(0);
    lens = '{8, 8, 7};
    send_frame(0, 1'b0, 0);
    n_tot++;
    if (live[0] !== e) $display("FAIL mismatch_887: got %s want %s", fmt(live[0]), fmt(e));
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    res_t e;
    e = mk(12, 6, 2, 1'b0, 1'b0, 1'b1);
    do_arm(0);
    vpulse(0);
    lens = '{6, 6};
    send_frame(0, 1'b1, 0);
    n_tot++;
    if (live[0] !== e) $display("FAIL same_cycle_2x6: got %s want %s", fmt(live[0]), fmt(e));
    else n_pass++;
  endtask

  task automatic test_random_single();
    int base, n, partial;
    bit same;
    res_t e;
    for (int it = 0; it < 8; it++) begin
      do_arm(0);
      vpulse(0);
      lens.delete();
      n = (it == 0) ? 0 : int'($urandom_range(1, 5));
      for (int k = 0; k < n; k++) lens.push_back(int'($urandom_range(1, 12)));
      partial = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
      if (it == 0) partial = 0;
      same = 1'($urandom_range(0, 1));
      base = dp_cnt[0];
      send_frame(0, same, partial);
      e = model(20, partial);
      n_tot++;
      if (dp_cnt[0] - base !== 1 || live[0] !== e)
        $display("FAIL rand_ss[%0d]: got %s pulses=%0d want %s pulses=1",
                 it, fmt(live[0]), dp_cnt[0] - base, fmt(e));
      else n_pass++;
    end
  endtask

  task automatic test_continuous();
    int base;
    res_t e1, e2;
    e1 = mk(8, 4, 2, 1'b0, 1'b0, 1'b1);
    e2 = mk(15, 5, 3, 1'b0, 1'b0, 1'b1);
    vpulse(1);
    base = dp_cnt[1];
    lens = '{4, 4};
    send_frame(1, 1'b0, 0);
    n_tot++;
    if (dp_cnt[1] - base !== 1 || last[1] !== e1)
      $display("FAIL cont_2x4: got %s pulses=%0d want %s pulses=1", fmt(last[1]), dp_cnt[1] - base, fmt(e1));
    else n_pass++;
    lens = '{5, 5, 5};
    send_frame(1, 1'b0, 0);
    n_tot++;
    if (dp_cnt[1] - base !== 2 || last[1] !== e2)
      $display("FAIL cont_3x5: got %s pulses=%0d want %s pulses=2", fmt(last[1]), dp_cnt[1] - base, fmt(e2));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int base, n;
    bit same;
    res_t e;
    base = dp_cnt[1];
    for (int it = 0; it < 6; it++) begin
      lens.delete();
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) lens.push_back(int'($urandom_range(1, 10)));
      same = 1'($urandom_range(0, 1));
      if (it == 0) arm_s[1] = 1'b1;
      send_frame(1, same, 0);
      arm_s[1] = 1'b0;
      e = model(20, 0);
      n_tot++;
      if (dp_cnt[1] - base !== it + 1 || last[1] !== e)
        $display("FAIL b2b[%0d]: got %s pulses=%0d want %s pulses=%0d",
                 it, fmt(last[1]), dp_cnt[1] - base, fmt(e), it + 1);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    res_t e1, e2;
    e1 = mk(15, 15, 1, 1'b0, 1'b1, 1'b1);
    e2 = mk(6, 3, 2, 1'b0, 1'b0, 1'b1);
    vpulse(2);
    lens = '{20};
    send_frame(2, 1'b0, 0);
    n_tot++;
    if (last[2] !== e1) $display("FAIL ovf_20: got %s want %s", fmt(last[2]), fmt(e1));
    else n_pass++;
    lens = '{3, 3};
    send_frame(2, 1'b0, 0);
    n_tot++;
    if (last[2] !== e2) $display("FAIL ovf_clear_2x3: got %s want %s", fmt(last[2]), fmt(e2));
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int base;
    res_t e;
    e = mk(10, 5, 2, 1'b0, 1'b0, 1'b1);
    do_arm(0);
    vpulse(0);
    href_s[0] = 1'b1;
    repeat (3) tick();
    vs_s[0] = 1'b1;
    do_reset();
    n_tot++;
    if (live[0] !== rst_val(0) || busy_l[0] !== 1'b0)
      $display("FAIL midframe_reset: got %s busy=%b want %s busy=0", fmt(live[0]), busy_l[0], fmt(rst_val(0)));
    else n_pass++;
    base = dp_cnt[0];
    repeat (2) tick();
    href_s[0] = 1'b0;
    do_arm(0);
    repeat (2) tick();
    vs_s[0] = 1'b0;
    lens = '{7};
    send_frame(0, 1'b0, 0);
    n_tot++;
    if (dp_cnt[0] - base !== 0)
      $display("FAIL midframe_no_pulse: got pulses=%0d want 0", dp_cnt[0] - base);
    else n_pass++;
    lens = '{5, 5};
    send_frame(0, 1'b0, 0);
    n_tot++;
    if (dp_cnt[0] - base !== 1 || live[0] !== e)
      $display("FAIL midframe_recover: got %s pulses=%0d want %s pulses=1", fmt(live[0]), dp_cnt[0] - base, fmt(e));
    else n_pass++;
  endtask

  task automatic test_pulse_width();
    n_tot++;
    if (width_err !== 0) $display("FAIL done_pulse_width: got %0d wide pulses want 0", width_err);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      href_s[i] = 1'b0;
      vs_s[i]   = 1'b0;
      arm_s[i]  = 1'b0;
    end
    test_reset();
    test_single_shot();
    test_mismatch();
    test_same_cycle();
    test_random_single();
    test_continuous();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_pulse_width();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/cam_frame_profiler.md
# cam_frame_profiler

Parametrised camera-frame geometry measurer on the `pclk` domain, driven by the camera `href`/`vsync` strobes. It measures, for one complete frame or for every frame:
- total active bytes,
- bytes in the first line,
- number of lines,
- whether every line matched the first line's length.

Results are registered and announced with a one-cycle pulse. It is used to bring up sensor configurations and to size downstream frame buffers.

## Interface
- `BYTE_W`, 20, width of `frame_bytes` and `line_bytes` counters
- `LINE_W`, 12, width of `line_count`
- `VSYNC_ACT_HIGH`, 1, 1: `vsync` high = vertical blanking; 0: `vsync` low = blanking
- `CONTINUOUS`, 0, 0: single-shot (measure one frame after `arm`, then hold); 1: re-measure every frame
- `pclk` in 1, camera pixel clock; all logic on rising edge
- `reset` in 1, synchronous, active-high
- `href` in 1, line-valid; one byte per `pclk` while high and `vsync` inactive
- `vsync` in 1, frame sync, polarity per `VSYNC_ACT_HIGH`
- `arm` in 1, single-cycle request to start a measurement (single-shot only)
- `frame_bytes` out BYTE_W, active bytes in measured frame
- `line_bytes` out BYTE_W, byte length of first completed line
- `line_count` out LINE_W, completed lines in frame
- `line_mismatch` out 1, some completed line length differed from `line_bytes`
- `overflow` out 1, a counter saturated during the measured frame
- `result_valid` out 1, results hold a completed measurement
- `done_pulse` out 1, one cycle when results update
- `busy` out 1, FSM in SYNC or COUNT

## Operation
- Internal terms:
  - `vs_act` = `vsync` normalised to active-high.
  - Frame edge = `vs_act` & ~`vs_act_d`.
  - Line end = `href_d` & ~`href`.
  - Byte strobe = `href` & ~`vs_act`.
- FSM states: IDLE, SYNC, COUNT, DONE.
  - IDLE: `busy`=0. `arm` → SYNC. When `CONTINUOUS`=1, IDLE → SYNC unconditionally one cycle after reset.
  - SYNC: clear the work counters. Frame edge → COUNT.
  - COUNT: count.
    - Byte strobe increments `cur_line` and `cur_frame`.
    - Line end increments `cur_lines`.
    - On the first line end, capture `cur_line` as `first_line`.
    - On later line ends, compare `cur_line` to `first_line`; any difference sets sticky `mm`.
    - `cur_line` clears on every line end.
    - Frame edge: register all results, `result_valid`←1, `done_pulse`←1.
      - `CONTINUOUS`=0: go to DONE.
      - `CONTINUOUS`=1: stay in COUNT with the work counters cleared. This closing edge is also the next frame's opening edge, so no frame is skipped.
  - DONE: hold results. `arm` → SYNC and `result_valid`←0.
- `arm` is ignored in SYNC and COUNT, and always ignored when `CONTINUOUS`=1.
- Width and saturation:
  - Every counter saturates at all-ones; it never wraps.
  - Any saturation sets sticky `ovf`, which is reported as `overflow` with the results.
  - `ovf` and `mm` clear when the work counters clear.
- Partial line (`href` still high at the frame edge): its bytes are included in `frame_bytes`; it is not counted in `line_count` and not compared.
- Line end in the same cycle as the frame edge: the line is counted and compared before the results are registered.
- Zero-line frame: results are `frame_bytes`=0, `line_bytes`=0, `line_count`=0, `line_mismatch`=0, with `result_valid`=1.
- Reset values:
  - `frame_bytes`, `line_bytes`, `line_count`: all ones.
  - `line_mismatch`, `overflow`, `result_valid`, `done_pulse`, `busy`: 0.
  - `href_d`: 0.
  - `vs_act_d`: 1, so `vsync` already active at reset release does not produce a false edge.
- Reset mid-frame aborts the measurement; a new measurement starts from the next full frame edge.

## Timing
- Frame edge sampled in cycle N → results and `done_pulse` visible in cycle N+1. `done_pulse` is exactly one cycle wide.
- `arm` sampled in cycle N → `busy`=1 in N+1.
- Byte strobe is evaluated on the same cycle as the line-end and frame-edge logic; it has no pipeline delay.
- Outputs are stable between `done_pulse` events.

## Test plan
- Single-shot, `VSYNC_ACT_HIGH`=1: reset; arm; vsync pulse; 3 lines × 8 bytes; vsync pulse.
  - Required: `frame_bytes`=24, `line_bytes`=8, `line_count`=3, `line_mismatch`=0, one `done_pulse`, `result_valid`=1.
  - A following 2×4 frame leaves the outputs unchanged.
- Line lengths 8, 8, 7 → `frame_bytes`=23, `line_bytes`=8, `line_count`=3, `line_mismatch`=1.
- `CONTINUOUS`=1, `VSYNC_ACT_HIGH`=0: back-to-back frames 2×4 then 3×5.
  - Required: two `done_pulse`s, with results 8/4/2 then 15/5/3.
- `BYTE_W`=4: one 20-byte line → `frame_bytes`=15, `line_bytes`=15, `overflow`=1.
  - The next frame (`CONTINUOUS`=1) of 2×3 gives `overflow`=0.
- Reset asserted mid-line with `vsync` held active through reset release.
  - Required: outputs at reset values; no `done_pulse` until an inactive→active edge plus a full frame.
- `href` falls in the same cycle as the closing frame edge on a 2×6 frame → `line_count`=2, `frame_bytes`=12.
